// File: rtl/sub_shift_pkg.sv
// Shared types and status codes for the pipelined subtract-shift unit.
package sub_shift_pkg;

  // Overflow handling selected per operation
  typedef enum logic [1:0] {
    MODE_FLAG = 2'b00,
    MODE_SAT  = 2'b01,
    MODE_WRAP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam logic [3:0] ST_OK      = 4'b0000;
  localparam logic [3:0] ST_ZERO    = 4'b0001;
  localparam logic [3:0] ST_OVF     = 4'b1001;
  localparam logic [3:0] ST_SAT     = 4'b1010;
  localparam logic [3:0] ST_WRAP    = 4'b1011;
  localparam logic [3:0] ST_BADMODE = 4'b1110;

endpackage

// File: rtl/sub_shift_fmt.sv
// Classifies an exact E-bit difference against the K-bit result range and
// formats result/status according to the overflow mode. Purely combinational.
module sub_shift_fmt
  import sub_shift_pkg::*;
#(
  parameter int unsigned E = 17,
  parameter int unsigned K = 8
) (
  input  logic [E-1:0] d,
  input  mode_e        mode,
  output logic [K-1:0] result,
  output logic [3:0]   status,
  output logic         ovf
);

  logic         out_of_range;
  logic [K-1:0] d_k;

  if (E > K) begin : g_narrow
    assign d_k = d[K-1:0];
    // Fits in K bits only if every bit from K-1 upward matches the sign bit
    assign out_of_range = (d[E-1:K-1] != {(E-K+1){d[E-1]}});
  end else begin : g_wide
    assign d_k          = K'($signed(d));
    assign out_of_range = 1'b0;
  end

  // Mode-dependent formatting; reserved mode ignores the range check
  always_comb begin
    result = '0;
    status = ST_OK;
    ovf    = 1'b0;
    if (mode == MODE_RSVD) begin
      status = ST_BADMODE;
    end else if (out_of_range) begin
      ovf = 1'b1;
      case (mode)
        MODE_FLAG: status = ST_OVF;
        MODE_SAT: begin
          status = ST_SAT;
          result = d[E-1] ? {1'b1, {(K-1){1'b0}}} : {1'b0, {(K-1){1'b1}}};
        end
        MODE_WRAP: begin
          status = ST_WRAP;
          result = d_k;
        end
        default: ;
      endcase
    end else begin
      result = d_k;
      status = (d_k == '0) ? ST_ZERO : ST_OK;
    end
  end

endmodule

// File: rtl/sub_shift_pipe.sv
// Two-stage valid/ready pipeline computing A - (B << shift) with selectable
// overflow handling and a saturating count of overflowed results delivered.
module sub_shift_pipe
  import sub_shift_pkg::*;
#(
  parameter int unsigned M  = 8,
  parameter int unsigned K  = 8,
  parameter int unsigned SW = $clog2(M),
  parameter int unsigned CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [M-1:0]  i_arg_A,
  input  logic [M-1:0]  i_arg_B,
  input  logic [SW-1:0] i_shift,
  input  logic [1:0]    i_mode,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [K-1:0]  o_result,
  output logic [3:0]    o_status,
  output logic [CW-1:0] o_ovf_cnt,
  input  logic          i_clr_cnt
);

  // 2M+1 bits hold the exact difference for any legal shift
  localparam int unsigned E = 2 * M + 1;

  logic          s1_valid;
  logic [E-1:0]  s1_d;
  mode_e         s1_mode;
  logic          ovf_q;
  logic          s1_adv;
  logic          s2_adv;
  logic [SW-1:0] sh;
  logic [E-1:0]  a_ext;
  logic [E-1:0]  b_ext;
  logic [E-1:0]  d_new;
  logic [K-1:0]  f_result;
  logic [3:0]    f_status;
  logic          f_ovf;

  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv;

  // Shift codes past M-1 only exist when M is not a power of two
  if ((1 << SW) > M) begin : g_clamp
    assign sh = (i_shift >= SW'(M - 1)) ? SW'(M - 1) : i_shift;
  end else begin : g_noclamp
    assign sh = i_shift;
  end

  assign a_ext = {{(E-M){i_arg_A[M-1]}}, i_arg_A};
  assign b_ext = {{(E-M){i_arg_B[M-1]}}, i_arg_B};
  assign d_new = a_ext - (b_ext << sh);

  // Stage 1: capture exact difference and mode when a bundle is accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_mode  <= MODE_FLAG;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_d    <= d_new;
        s1_mode <= mode_e'(i_mode);
      end
    end
  end

  sub_shift_fmt #(
    .E(E),
    .K(K)
  ) u_fmt (
    .d     (s1_d),
    .mode  (s1_mode),
    .result(f_result),
    .status(f_status),
    .ovf   (f_ovf)
  );

  // Stage 2: latch formatted result; holds while downstream stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_status <= ST_OK;
      ovf_q    <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_result <= f_result;
        o_status <= f_status;
        ovf_q    <= f_ovf;
      end
    end
  end

  // Overflow counter: counts on delivery, saturates, clear has priority
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ovf_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_ovf_cnt <= '0;
    end else if (o_valid && i_ready && ovf_q && (o_ovf_cnt != '1)) begin
      o_ovf_cnt <= o_ovf_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_sub_shift_pipe.sv
// Scoreboard bench for sub_shift_pipe with M=K=8, CW=2.
module tb_sub_shift_pipe;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_arg_A;
  logic [7:0] i_arg_B;
  logic [2:0] i_shift;
  logic [1:0] i_mode;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_result;
  logic [3:0] o_status;
  logic [1:0] o_ovf_cnt;
  logic       i_clr_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_del = 0;
  logic [11:0] exp_q[$];
  int          del_cyc[$];
  logic [11:0] mon_e;

  sub_shift_pipe #(
    .M (8),
    .K (8),
    .CW(2)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_arg_A  (i_arg_A),
    .i_arg_B  (i_arg_B),
    .i_shift  (i_shift),
    .i_mode   (i_mode),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_status (o_status),
    .o_ovf_cnt(o_ovf_cnt),
    .i_clr_cnt(i_clr_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {result[7:0], status[3:0]}
  function automatic logic [11:0] model(input int a, input int b, input int sh, input int md);
    int d;
    logic [7:0] r;
    logic [3:0] s;
    d = a - b * (1 << sh);
    if (md == 3) begin
      r = 8'h00; s = 4'b1110;
    end else if (d > 127 || d < -128) begin
      if (md == 0) begin
        r = 8'h00; s = 4'b1001;
      end else if (md == 1) begin
        r = (d > 127) ? 8'h7f : 8'h80; s = 4'b1010;
      end else begin
        r = d[7:0]; s = 4'b1011;
      end
    end else begin
      r = d[7:0];
      s = (r == 8'h00) ? 4'b0001 : 4'b0000;
    end
    return {r, s};
  endfunction

  // Drive one bundle from a negedge until accepted; returns at the next negedge
  task automatic issue(input int a, input int b, input int sh, input int md);
    int n = 0;
    i_valid = 1'b1;
    i_arg_A = 8'(a);
    i_arg_B = 8'(b);
    i_shift = 3'(sh);
    i_mode  = 2'(md);
    #1;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(o_ready), 1);
    exp_q.push_back(model(a, b, sh, md));
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge i_clk);
      #3;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    @(negedge i_clk);
  endtask

  // Monitor: pop and compare on every delivery
  always @(negedge i_clk) begin
    #2;
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_out", 32'(exp_q.size()), 1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", 32'(o_result), 32'(mon_e[11:4]));
        chk("status", 32'(o_status), 32'(mon_e[3:0]));
      end
      n_del++;
      del_cyc.push_back(cyc);
    end
  end

  initial begin
    int a4[4] = '{1, 2, -5, 50};
    int b4[4] = '{0, 0, 2, -10};
    int s4[4] = '{0, 0, 2, 3};
    int m4[4] = '{0, 1, 2, 0};
    int idx;
    int del0;
    logic acc;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_clr_cnt = 1'b0;
    i_arg_A = '0; i_arg_B = '0; i_shift = '0; i_mode = '0;
    #2;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_result", 32'(o_result), 0);
    chk("rst_status", 32'(o_status), 0);
    chk("rst_cnt", 32'(o_ovf_cnt), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_ready", 32'(o_ready), 1);
    @(negedge i_clk);

    // 1: latency and throughput
    issue(10, 3, 1, 0);
    #1;
    chk("lat_early", 32'(o_valid), 0);
    @(negedge i_clk);
    #1;
    chk("lat_valid", 32'(o_valid), 1);
    chk("lat_result", 32'(o_result), 32'h04);
    drain();
    del_cyc.delete();
    issue(6, 3, 1, 0);
    issue(7, 1, 0, 0);
    issue(-3, 1, 1, 0);
    issue(20, 5, 2, 0);
    drain();
    chk("b2b_count", 32'(del_cyc.size()), 4);
    if (del_cyc.size() == 4) chk("b2b_span", 32'(del_cyc[3] - del_cyc[0]), 3);

    // 2: overflow modes and counter saturation
    issue(-128, 1, 1, 0);
    drain(); #1; chk("cnt1", 32'(o_ovf_cnt), 1);
    issue(-128, 1, 1, 1);
    drain(); #1; chk("cnt2", 32'(o_ovf_cnt), 2);
    issue(-128, 1, 1, 2);
    drain(); #1; chk("cnt3", 32'(o_ovf_cnt), 3);
    issue(-128, 1, 1, 0);
    drain(); #1; chk("cnt_sat", 32'(o_ovf_cnt), 3);

    // 3: positive saturation and wrap to zero without zero status
    issue(100, -20, 1, 1);
    issue(0, -128, 7, 2);
    drain();

    // 4: backpressure
    i_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      i_valid = 1'b1;
      i_arg_A = 8'(a4[idx]);
      i_arg_B = 8'(b4[idx]);
      i_shift = 3'(s4[idx]);
      i_mode  = 2'(m4[idx]);
      #1;
      acc = o_ready;
      @(negedge i_clk);
      if (acc) begin
        exp_q.push_back(model(a4[idx], b4[idx], s4[idx], m4[idx]));
        idx++;
      end
    end
    #1;
    chk("bp_accepted", 32'(idx), 2);
    chk("bp_ready", 32'(o_ready), 0);
    for (int c = 0; c < 3; c++) begin
      chk("hold_result", 32'(o_result), 32'(exp_q[0][11:4]));
      chk("hold_status", 32'(o_status), 32'(exp_q[0][3:0]));
      @(negedge i_clk);
      #1;
    end
    @(negedge i_clk);
    del0 = n_del;
    i_ready = 1'b1;
    for (int j = idx; j < 4; j++) issue(a4[j], b4[j], s4[j], m4[j]);
    drain();
    chk("bp_delivered", 32'(n_del - del0), 4);

    // 5: reserved mode and clear priority
    i_clr_cnt = 1'b1;
    @(negedge i_clk);
    i_clr_cnt = 1'b0;
    #1;
    chk("clr_cnt", 32'(o_ovf_cnt), 0);
    @(negedge i_clk);
    issue(1, 0, 0, 3);
    drain(); #1; chk("rsvd_cnt", 32'(o_ovf_cnt), 0);
    issue(-128, 1, 1, 0);
    drain(); #1; chk("cnt_after_clr", 32'(o_ovf_cnt), 1);
    @(negedge i_clk);
    issue(-128, 1, 1, 1);
    idx = 0;
    #1;
    while (!o_valid && idx < 10) begin
      @(negedge i_clk);
      #1;
      idx++;
    end
    chk("clr_wait", 32'(o_valid), 1);
    i_clr_cnt = 1'b1;
    @(negedge i_clk);
    i_clr_cnt = 1'b0;
    #1;
    chk("clr_wins", 32'(o_ovf_cnt), 0);
    drain();

    // 6: reset with both stages full
    i_ready = 1'b0;
    issue(5, 1, 0, 0);
    issue(9, 1, 0, 0);
    #1;
    i_rst = 1'b1;
    #1;
    chk("rst6_valid", 32'(o_valid), 0);
    chk("rst6_result", 32'(o_result), 0);
    chk("rst6_status", 32'(o_status), 0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("rst6_ready", 32'(o_ready), 1);
    chk("rst6_cnt", 32'(o_ovf_cnt), 0);
    @(negedge i_clk);
    issue(-7, 3, 2, 2);
    #1;
    chk("rst6_lat_early", 32'(o_valid), 0);
    @(negedge i_clk);
    #1;
    chk("rst6_lat_valid", 32'(o_valid), 1);
    drain();
    chk("q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_shift_pipe.md
Name: sub_shift_pipe

Overview:
Pipelined, parametrised successor to the combinational subtract-and-double unit. Computes A - (B << shift) with a runtime shift amount and a runtime overflow-handling mode (flag / saturate / wrap). Uses a 2-stage valid/ready pipeline and keeps a sticky overflow event counter. Sits in the datapath's arithmetic unit group, between operand issue and the result/status writeback.

Parameters:
M, 8, operand width (signed two's complement), M >= 2
K, 8, result width (signed), K >= 2
SW, $clog2(M), width of shift amount; legal shifts 0..M-1
CW, 8, width of overflow event counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_valid  in  1  input operand bundle valid
o_ready  out  1  unit can accept a bundle this cycle
i_arg_A  in  M  minuend, signed
i_arg_B  in  M  subtrahend base, signed
i_shift  in  SW  left-shift applied to B; values >= M treated as M-1
i_mode  in  2  00 flag, 01 saturate, 10 wrap, 11 reserved
o_valid  out  1  result bundle valid
i_ready  in  1  downstream accepts result
o_result  out  K  signed result
o_status  out  4  status code
o_ovf_cnt  out  CW  count of overflowed results delivered
i_clr_cnt  in  1  synchronous clear of o_ovf_cnt

Behaviour:
- Reset (async assert): both stage valids 0, o_valid 0, o_result 0, o_status 4'b0000, o_ovf_cnt 0. In-flight ops dropped. o_ready = 1 the first cycle after release.
- Input accepted when i_valid && o_ready. Output delivered when o_valid && i_ready.
- Stage 1: compute exact difference D = sext(A) - (sext(B) << shift) at width E = 2M+1, which never overflows. Latch D, mode, valid.
- Stage 2: classify and format, then latch o_result/o_status. Latency is exactly 2 cycles from acceptance to o_valid with no stall. Throughput is 1 op/cycle.
- Flow control: s2_adv = !o_valid || i_ready; s1_adv = !s1_valid || s2_adv; o_ready = s1_adv. This is a combinational ready path with no skid buffer.
- While o_valid && !i_ready: o_result, o_status and the stage-1 contents hold stable. No loss, no duplication, order preserved.
- Overflow: D > 2^(K-1)-1 or D < -2^(K-1).
- Mode 00 flag: on overflow, result 0, status 4'b1001.
- Mode 01 saturate: on overflow, result clamps to 2^(K-1)-1 or -2^(K-1), status 4'b1010.
- Mode 10 wrap: on overflow, result D[K-1:0], status 4'b1011.
- Mode 11: result 0, status 4'b1110, regardless of overflow; not counted as overflow.
- No overflow (modes 00-10): result D[K-1:0], status 4'b0001 if result == 0, else 4'b0000.
- Outputs are never X.
- Counter: increments by 1 on each delivered result whose status is 1001, 1010 or 1011. It saturates at 2^CW-1 and does not wrap. i_clr_cnt sets it to 0; clear wins over a same-cycle increment.
- Mode and shift are sampled with the operands. Later changes do not affect in-flight ops.

Decomposition:
- Package sub_shift_pkg holds:
  - mode enum: MODE_FLAG, MODE_SAT, MODE_WRAP, MODE_RSVD.
  - status constants: ST_OK 0000, ST_ZERO 0001, ST_OVF 1001, ST_SAT 1010, ST_WRAP 1011, ST_BADMODE 1110.
- One combinational sub-module, sub_shift_fmt: takes D (E bits) and mode, returns result, status and ovf flag. Used in stage 2.
- Top level holds the stage registers, handshake logic and counter.

Test Plan (M=K=8, CW=2 unless noted; i_ready=1 unless noted):
1. A=10, B=3, shift=1, mode 00 -> o_valid exactly 2 cycles after acceptance, result 0x04, status 0000. Then A=6, B=3, shift=1 -> result 0x00, status 0001. Back-to-back issue yields one result per cycle.
2. A=-128, B=1, shift=1 (D=-130) in modes 00, 01, 10 -> results 0x00, 0x80, 0x7E with statuses 1001, 1010, 1011. o_ovf_cnt goes 1, 2, 3, then stays 3 on a fourth overflow (saturates).
3. A=100, B=-20, shift=1 (D=140), mode 01 -> 0x7F, status 1010. Then A=0, B=-128, shift=7 (D=16384), mode 10 -> 0x00, status 1011; no false zero status.
4. Backpressure: issue 4 ops with i_ready=0 -> o_ready drops after 2 accepted; o_result/o_status stable while held. Raise i_ready -> all 4 results delivered in order, none lost or duplicated.
5. Mode 11 with A=1, B=0 -> result 0, status 1110, counter unchanged. i_clr_cnt asserted in the same cycle as an overflow delivery -> counter reads 0.
6. Assert i_rst with both stages full -> same-cycle o_valid 0 and outputs 0. After release, o_ready=1 and the next op completes with normal 2-cycle latency.
